// File: rtl/residual_fork.sv
// Residual fork: duplicates one AXI-Stream into a registered main branch and a FWFT residual FIFO.
// Optional packet-length checker enabled by defining RESIDUAL_FORK_LEN_CHECK_EN.
module residual_fork #(
    parameter int D_W        = 8,
    parameter int FIFO_DEPTH = 64,
    parameter int PKT_LEN    = 768
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [D_W-1:0]                in_tdata_X,
    input  logic                          in_tvalid_X,
    input  logic                          in_tlast_X,
    output logic                          in_tready_X,
    output logic [D_W-1:0]                out_tdata_M,
    output logic                          out_tvalid_M,
    output logic                          out_tlast_M,
    input  logic                          out_tready_M,
    output logic [D_W-1:0]                out_tdata_R,
    output logic                          out_tvalid_R,
    output logic                          out_tlast_R,
    input  logic                          out_tready_R,
    output logic [$clog2(FIFO_DEPTH):0]   r_level,
    output logic                          len_err
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int EW = D_W + 1;

    generate
        if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || PKT_LEN < 1) begin : g_param_check
            $error("residual_fork: FIFO_DEPTH must be a power of 2 >= 2 and PKT_LEN >= 1");
        end
    endgenerate

    logic                 main_valid_reg;
    logic [D_W-1:0]       main_data_reg;
    logic                 main_last_reg;

    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_reg;
    logic [AW-1:0]        rd_ptr_reg;
    logic [AW-1:0]        rd_ptr_next;
    logic [LW-1:0]        level_reg;
    logic [LW-1:0]        level_next;
    logic [EW-1:0]        head_reg;
    logic [EW-1:0]        wr_word;

    logic                 main_rdy;
    logic                 res_rdy;
    logic                 wr_en;
    logic                 rd_en;

    // Handshake: a beat is taken only when both branches can absorb it together.
    assign main_rdy    = out_tready_M | ~main_valid_reg;
    assign rd_en       = out_tvalid_R & out_tready_R;
    assign res_rdy     = (level_reg < LW'(FIFO_DEPTH)) | rd_en;
    assign in_tready_X = ~rst & main_rdy & res_rdy;
    assign wr_en       = in_tvalid_X & in_tready_X;
    assign wr_word     = {in_tlast_X, in_tdata_X};

    // Main branch output register.
    always_ff @(posedge clk) begin
        if (rst) begin
            main_valid_reg <= 1'b0;
            main_data_reg  <= '0;
            main_last_reg  <= 1'b0;
        end else if (main_rdy) begin
            main_valid_reg <= in_tvalid_X & res_rdy;
            main_data_reg  <= in_tdata_X;
            main_last_reg  <= in_tlast_X;
        end
    end

    assign out_tvalid_M = main_valid_reg;
    assign out_tdata_M  = main_data_reg;
    assign out_tlast_M  = main_last_reg;

    // Residual FIFO storage and pointers.
    assign rd_ptr_next = rd_en ? rd_ptr_reg + AW'(1) : rd_ptr_reg;

    always_comb begin
        level_next = level_reg;
        case ({wr_en, rd_en})
            2'b10:   level_next = level_reg + LW'(1);
            2'b01:   level_next = level_reg - LW'(1);
            default: level_next = level_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= wr_word;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            level_reg  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + AW'(1);
            end
            rd_ptr_reg <= rd_ptr_next;
            level_reg  <= level_next;
        end
    end

    // Registered head read addressed by the next read pointer; a write landing on
    // that slot in the same cycle is forwarded so the head is valid one cycle later.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_reg <= '0;
        end else if (wr_en && (wr_ptr_reg == rd_ptr_next)) begin
            head_reg <= wr_word;
        end else begin
            head_reg <= mem[rd_ptr_next];
        end
    end

    assign out_tvalid_R = (level_reg != '0);
    assign out_tdata_R  = head_reg[D_W-1:0];
    assign out_tlast_R  = head_reg[D_W];
    assign r_level      = level_reg;

`ifdef RESIDUAL_FORK_LEN_CHECK_EN
    localparam int CW = $clog2(PKT_LEN) + 1;

    logic [CW-1:0] beat_cnt_reg;
    logic [CW-1:0] beat_cnt_next;
    logic [CW-1:0] cnt_inc;
    logic          len_err_reg;
    logic          len_err_next;

    always_comb begin
        beat_cnt_next = beat_cnt_reg;
        len_err_next  = len_err_reg;
        cnt_inc       = beat_cnt_reg + CW'(1);
        if (wr_en) begin
            if (in_tlast_X) begin
                if (cnt_inc != CW'(PKT_LEN)) begin
                    len_err_next = 1'b1;
                end
                beat_cnt_next = '0;
            end else if (cnt_inc == CW'(PKT_LEN)) begin
                // Packet reached its length without tlast.
                len_err_next  = 1'b1;
                beat_cnt_next = '0;
            end else begin
                beat_cnt_next = cnt_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_cnt_reg <= '0;
            len_err_reg  <= 1'b0;
        end else begin
            beat_cnt_reg <= beat_cnt_next;
            len_err_reg  <= len_err_next;
        end
    end

    assign len_err = len_err_reg;
`else
    assign len_err = 1'b0;
`endif

endmodule

// File: doc/residual_fork.md
# residual_fork

Stream fork that duplicates one AXI-Stream activation stream into a main-path output and a buffered residual (skip) output. It sits at the head of each transformer residual block. The main branch feeds the compute chain (matmul/GELU/etc.). The residual branch holds a copy of the same beats in a FIFO until the downstream element-wise adder consumes it, alongside the main-path result. Both outputs see every input beat exactly once, in order, with identical data and tlast.

## Interface
Parameters:
- D_W, 8, beat data width (signed).
- FIFO_DEPTH, 64, residual FIFO depth in beats; power of 2, ≥ 2.
- PKT_LEN, 768, expected beats per packet (tlast-delimited); used only with the length checker.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- in_tdata_X  in  D_W  input beat data (signed).
- in_tvalid_X  in  1  input valid.
- in_tlast_X  in  1  input last-of-packet.
- in_tready_X  out  1  input ready.
- out_tdata_M  out  D_W  main-branch data.
- out_tvalid_M  out  1  main-branch valid.
- out_tlast_M  out  1  main-branch last.
- out_tready_M  in  1  main-branch ready.
- out_tdata_R  out  D_W  residual-branch data.
- out_tvalid_R  out  1  residual-branch valid.
- out_tlast_R  out  1  residual-branch last.
- out_tready_R  in  1  residual-branch ready.
- r_level  out  $clog2(FIFO_DEPTH)+1  residual FIFO occupancy in beats.
- len_err  out  1  sticky packet-length error; tied 0 when the checker is compiled out.

## Operation
- **Lockstep fork.** A beat is accepted only when both branches can take it in the same cycle, so neither branch ever holds a beat the other lacks.
- **Main-branch readiness:** main_rdy = out_tready_M | ~out_tvalid_M.
- **Residual-branch readiness:** res_rdy = (r_level < FIFO_DEPTH) | (out_tvalid_R & out_tready_R). A full FIFO accepts a write in the same cycle as a read.
- **Input ready:** in_tready_X = ~rst & main_rdy & res_rdy. It never depends on in_tvalid_X.
- **Accept:** acc = in_tvalid_X & in_tready_X.
- **Main output register:**
  - When main_rdy: out_tvalid_M ← in_tvalid_X & res_rdy, and data/last ← input.
  - Otherwise it holds its contents.
- **Residual FIFO:**
  - Stores {tlast, tdata} per beat.
  - Write on acc; read on out_tvalid_R & out_tready_R.
  - Write pointer and read pointer are each $clog2(FIFO_DEPTH) bits and wrap modulo FIFO_DEPTH.
  - Occupancy: +1 on write only, −1 on read only, unchanged on simultaneous read and write.
- **Residual output:** first-word-fall-through. out_tvalid_R = (r_level != 0), and out_tdata_R/out_tlast_R show the head entry whenever valid.
- **Data path:** no arithmetic; both outputs are bit-exact copies of the input.
- **Ordering:** beats leave each branch in acceptance order, and a packet's tlast appears on the same beat index on both branches.
- **Reset mid-operation:** the main register and all FIFO contents are discarded, pointers go to 0, and len_err clears. Beats in flight are lost with no partial flush.

## Timing
- **Reset values:** out_tvalid_M=0, out_tdata_M=0, out_tlast_M=0, out_tvalid_R=0, r_level=0, len_err=0, in_tready_X=0 while rst is high. in_tready_X is 1 in the first cycle after reset release.
- **Latency:** a beat accepted at edge N is visible on the M branch and on the R branch (if the FIFO was empty) after edge N, i.e. one cycle later. A beat behind a non-empty FIFO appears when it reaches the head.
- **Throughput:** 1 beat/cycle sustained while both consumers are ready and the FIFO is not full.
- **Main stall:** a stall on M back-pressures the input immediately (same cycle); the R branch keeps draining.
- **Residual behaviour when M runs ahead:** with R stalled, the FIFO fills. At r_level = FIFO_DEPTH with no R read in that cycle, in_tready_X=0 and M stops receiving.
- **Empty FIFO:** out_tvalid_R=0 and out_tdata_R is don't-care.

## Configuration
- Macro: RESIDUAL_FORK_LEN_CHECK_EN.
- **Defined:**
  - A beat counter of $clog2(PKT_LEN)+1 bits counts accepted beats.
  - On an accepted tlast, len_err is set if count+1 != PKT_LEN, then the counter clears.
  - len_err is also set if count+1 reaches PKT_LEN on an accepted beat without tlast; the counter clears there too.
  - len_err is sticky until rst. Data flow is unaffected.
- **Undefined:** no counter is built and len_err is constantly 0.

## Test plan
- **Streaming:** after reset, stream 16 beats (0..15, tlast on 15) with both readies high → M and R each output 0..15 one cycle after acceptance, tlast only on 15, r_level ≤ 1, no bubbles.
- **Residual stall:** FIFO_DEPTH=4, out_tready_R=0, out_tready_M=1, stream 10 beats → M receives exactly 4 beats, r_level=4, in_tready_X=0. Raising out_tready_R drains 4 beats in order, and the remaining 6 then flow on both branches.
- **Full-FIFO read/write:** FIFO full and both readies high with in_tvalid_X=1 → write and read occur in the same cycle, r_level stays 4, no beat is lost or duplicated.
- **Main stall:** out_tready_M=0 for 5 cycles while a beat is held on M → out_tdata_M stable, in_tready_X=0, R drains its backlog to r_level=0.
- **Reset mid-operation:** assert rst with r_level=3 → next cycle out_tvalid_M=0, out_tvalid_R=0, r_level=0. After release, new beats appear starting from the first post-reset beat.
- **Length checker:** with RESIDUAL_FORK_LEN_CHECK_EN and PKT_LEN=8, send a packet with tlast on beat 6 → len_err=1 and stays set. A following 8-beat packet does not clear it. Only rst clears it.
